a0_trace_fifo: RTL
==================

// Module: a0_trace_fifo
// PURPOSE
//   Sits downstream of the CPU top, on the a0 result register output. Samples a0 every enabled cycle
//   and pushes a (value, cycle-stamp) record into a FWFT FIFO whenever a0 changes. A host/display
//   consumer drains records over a valid/ready handshake. Full-FIFO drops are counted and flagged.
// PARAMETERS
//   DATA_WIDTH   32  width of a0 and stored value
//   DEPTH        8   FIFO entries; power of 2, >= 2
//   STAMP_WIDTH  16  width of free-running cycle stamp
// PORTS
//   clk          input   1                      clock, all state on rising edge
//   rst          input   1                      asynchronous, active-low reset (0 = reset)
//   en_i         input   1                      capture enable (CPU running)
//   clear_i      input   1                      synchronous clear of FIFO, stamp, flags
//   a0_i         input   DATA_WIDTH             a0 from register file
//   out_data_o   output  DATA_WIDTH             head record value
//   out_stamp_o  output  STAMP_WIDTH            head record cycle stamp
//   out_valid_o  output  1                      head record present
//   out_ready_i  input   1                      consumer accepts head this cycle
//   count_o      output  $clog2(DEPTH)+1        entries held, 0..DEPTH
//   overflow_o   output  1                      sticky: >=1 record dropped
//   drop_cnt_o   output  16                     dropped records, saturates at 16'hFFFF
// BEHAVIOUR
//   - Reset (rst=0, async): pointers, count, stamp, prev_a0, overflow, drop_cnt all 0; every output 0.
//   - Stamp counter: +1 each cycle en_i=1, holds when en_i=0; wraps 2^STAMP_WIDTH-1 -> 0.
//   - Change detect: capture = en_i & (a0_i != prev_a0). prev_a0 <= a0_i each cycle en_i=1.
//     After reset prev_a0=0: first nonzero a0 is captured, a0 staying 0 is not.
//   - Pushed record = {a0_i, stamp value in the capture cycle (pre-increment)}.
//   - Pop = out_valid_o & out_ready_i. out_valid_o = (count != 0), registered-state only.
//   - FWFT: out_data_o/out_stamp_o show head entry when valid, 0 when count=0.
//     Capture in cycle N into empty FIFO -> out_valid_o=1 in cycle N+1. No combinational
//     path from a0_i or out_ready_i to any output.
//   - Valid/ready: once out_valid_o=1, head data stays stable until popped (clear excepted).
//   - Push accepted if count<DEPTH, or count==DEPTH with a simultaneous pop.
//     Push+pop same cycle: count unchanged, both pointers advance.
//   - Drop: capture while count==DEPTH and no pop -> record discarded, overflow_o<=1,
//     drop_cnt_o increments (saturating). FIFO contents untouched.
//   - Pointers index modulo DEPTH; count distinguishes full from empty.
//   - clear_i=1: count/pointers/stamp/overflow/drop_cnt <= 0; prev_a0 <= a0_i (no capture that
//     cycle). Clear overrides push, pop and drop in the same cycle.
//   - Reset asserted mid-operation: immediate return to reset state, in-flight records lost.
//   - en_i=0: no capture, prev_a0 and stamp hold; pops still serviced.
// TESTING
//   1 Reset: rst=0 with a0_i=5, en_i=1 -> all outputs 0; release, a0_i=5 -> record {5, stamp 0}
//     valid next cycle, count_o=1.
//   2 Steady a0: a0_i held 7 for 20 cycles, out_ready_i=1 -> exactly one record {7,*}, then
//     out_valid_o=0.
//   3 Fill/drop: out_ready_i=0, a0_i 1..10 on consecutive cycles, DEPTH=8 -> count_o=8, records
//     1..8 held, overflow_o=1, drop_cnt_o=2; drain yields 1..8 in order, stamps strictly increasing.
//   4 Full + simultaneous push/pop: count=8, out_ready_i=1, a0 change -> count stays 8, head
//     advances, drop_cnt_o unchanged.
//   5 Stamp wrap: STAMP_WIDTH=4, changes at cycles 14 and 17 -> stamps 14 and 1.
//   6 Clear with full FIFO and overflow set, a0 changing same cycle -> next cycle count_o=0,
//     overflow_o=0, drop_cnt_o=0, out_valid_o=0; following unchanged a0 -> no record.

Source files
------------

// File: rtl/a0_trace_fifo_if.sv
// rtl/a0_trace_fifo_if.sv - head-record stream between the a0 trace FIFO and its consumer
interface a0_trace_fifo_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int STAMP_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]  out_data_o;
  logic [STAMP_WIDTH-1:0] out_stamp_o;
  logic                   out_valid_o;
  logic                   out_ready_i;

  modport master (output out_data_o, out_stamp_o, out_valid_o, input out_ready_i);
  modport slave  (input out_data_o, out_stamp_o, out_valid_o, output out_ready_i);
endinterface

// File: rtl/a0_trace_fifo.sv
// rtl/a0_trace_fifo.sv - records a0 changes with a cycle stamp into a FWFT FIFO
module a0_trace_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int STAMP_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     clear_i,
  input  logic [DATA_WIDTH-1:0]    a0_i,
  a0_trace_fifo_if.master          out,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = DATA_WIDTH + STAMP_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [RW-1:0]          mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [STAMP_WIDTH-1:0] stamp;
  logic [DATA_WIDTH-1:0]  prev_a0;
  logic                   overflow;
  logic [15:0]            drop_cnt;

  logic          valid, full, capture, pop, push, drop;
  logic [RW-1:0] head;

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  // Clear suppresses every queue action in its cycle.
  assign capture = en_i && (a0_i != prev_a0) && !clear_i;
  assign pop     = valid && out.out_ready_i && !clear_i;
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;
  assign head    = mem[rd_ptr];

  assign out.out_valid_o = valid;
  assign out.out_data_o  = valid ? head[RW-1:STAMP_WIDTH] : '0;
  assign out.out_stamp_o = valid ? head[STAMP_WIDTH-1:0] : '0;
  assign count_o         = count;
  assign overflow_o      = overflow;
  assign drop_cnt_o      = drop_cnt;

  // Storage needs no reset: outputs are masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {a0_i, stamp};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      stamp    <= '0;
      prev_a0  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      stamp    <= '0;
      prev_a0  <= a0_i;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (en_i) begin
        stamp   <= stamp + 1'b1;
        prev_a0 <= a0_i;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
endmodule
